// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversamples the asynchronous rx pin at the system clock
// and presents each good byte on a valid/ready holding register.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_T = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic          rx_meta_r;
    logic          rx_s_r;
    state_t        state_r;
    state_t        state_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_s;
    logic          good_s;
    logic          bad_s;
    logic [7:0]    data_r;
    logic          valid_r;
    logic          frame_err_r;
    logic          overrun_r;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
        end
    end

    // Frame FSM state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
        end
    end

    // Next-state logic; good_s/bad_s strobe on the stop-sample cycle.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r + TW'(1);
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        good_s    = 1'b0;
        bad_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                timer_s = '0;
                if (!rx_s_r) state_s = S_START;
                else         state_s = S_IDLE;
            end
            S_START: begin
                if (timer_r == HALF_T) begin
                    timer_s = '0;
                    if (!rx_s_r) begin
                        state_s   = S_DATA;
                        bit_idx_s = 3'd0;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_START;
                end
            end
            S_DATA: begin
                if (timer_r == LAST_T) begin
                    timer_s = '0;
                    shift_s = {rx_s_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) state_s = S_STOP;
                    else                   bit_idx_s = bit_idx_r + 3'd1;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_STOP: begin
                if (timer_r == LAST_T) begin
                    timer_s = '0;
                    if (rx_s_r) begin
                        good_s  = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        bad_s   = 1'b1;
                        state_s = S_BREAK;
                    end
                end else begin
                    state_s = S_STOP;
                end
            end
            S_BREAK: begin
                // Held-low line must return high before another frame is decoded.
                timer_s = '0;
                if (rx_s_r) state_s = S_IDLE;
                else        state_s = S_BREAK;
            end
            default: begin
                state_s = S_IDLE;
                timer_s = '0;
            end
        endcase
    end

    // Holding register and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= bad_s;
            overrun_r   <= good_s & valid_r & ~ready;
            if (good_s && (!valid_r || ready)) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign data      = data_r;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx; received bytes are compared
// against a queue of the bytes the bench put on the wire.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b1;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
        .ready(ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Observer: record accepted bytes and error pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) rxq.push_back(data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_queue(input string tag);
        check({tag, "_count"}, rxq.size(), expq.size());
        if (rxq.size() == expq.size()) begin
            for (int i = 0; i < expq.size(); i++) check({tag, "_byte"}, rxq[i], expq[i]);
        end
        rxq.delete();
        expq.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame, each bit held exactly C cycles; called aligned just after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_cycles(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(C);
        end
        rx = stop_bit;
        wait_cycles(C);
        rx = 1'b1;
    endtask

    int lat;
    int seen;
    int fe0;
    int ov0;
    int gap;
    logic [7:0] rb;

    initial begin
        // Reset state
        rst_n = 1'b0;
        wait_cycles(3);
        check("reset_data", data, 8'h00);
        check("reset_valid", valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        wait_cycles(5);

        // 0xA5 latency and accept
        fe0 = fe_cnt; ov0 = ov_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0; seen = 0;
                for (int i = 0; i < 300 && seen == 0; i++) begin
                    @(posedge clk); #1;
                    lat++;
                    if (valid) seen = 1;
                end
                check("a5_seen", seen, 1);
                check("a5_latency_in_155_156", (lat >= 155 && lat <= 156), 1'b1);
                check("a5_data", data, 8'hA5);
                wait_cycles(1);
                check("a5_valid_clears", valid, 1'b0);
            end
        join
        wait_cycles(10);
        check("a5_no_frame_err", fe_cnt - fe0, 0);
        check("a5_no_overrun", ov_cnt - ov0, 0);
        expq.push_back(8'hA5);
        check_queue("a5_queue");

        // Overrun: three frames while consumer stalls
        ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        wait_cycles(10);
        check("ovr_valid_held", valid, 1'b1);
        check("ovr_data_held", data, 8'h00);
        check("ovr_pulses", ov_cnt - ov0, 2);
        ready = 1'b1;
        wait_cycles(1);
        check("ovr_valid_falls", valid, 1'b0);
        wait_cycles(30);
        expq.push_back(8'h00);
        check_queue("ovr_queue");

        // Glitch of 5 cycles, then a clean 0x3C
        fe0 = fe_cnt; ov0 = ov_cnt;
        rx = 1'b0;
        wait_cycles(5);
        rx = 1'b1;
        wait_cycles(30);
        check("glitch_no_valid", rxq.size(), 0);
        send_frame(8'h3C, 1'b1);
        wait_cycles(20);
        check("glitch_no_frame_err", fe_cnt - fe0, 0);
        check("glitch_no_overrun", ov_cnt - ov0, 0);
        expq.push_back(8'h3C);
        check_queue("glitch_queue");

        // Framing error then break, then 0x42
        fe0 = fe_cnt;
        send_frame(8'h81, 1'b0);
        rx = 1'b0;
        wait_cycles(40);
        rx = 1'b1;
        wait_cycles(20);
        check("ferr_one_pulse", fe_cnt - fe0, 1);
        send_frame(8'h42, 1'b1);
        wait_cycles(20);
        expq.push_back(8'h42);
        check_queue("ferr_queue");

        // Accept collision on the completion cycle of 0x22
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        wait_cycles(5);
        check("coll_first_valid", valid, 1'b1);
        check("coll_first_data", data, 8'h11);
        ov0 = ov_cnt;
        fork
            send_frame(8'h22, 1'b1);
            begin
                wait_cycles(155);
                ready = 1'b1;
                wait_cycles(1);
                ready = 1'b0;
            end
        join
        wait_cycles(5);
        check("coll_valid", valid, 1'b1);
        check("coll_data", data, 8'h22);
        check("coll_no_overrun", ov_cnt - ov0, 0);
        expq.push_back(8'h11);
        check_queue("coll_accept_queue");
        ready = 1'b1;
        wait_cycles(5);
        expq.push_back(8'h22);
        check_queue("coll_drain_queue");

        // Reset in the middle of 0x77's data bits
        ready = 1'b0;
        send_frame(8'h33, 1'b1);
        wait_cycles(5);
        fe0 = fe_cnt;
        fork
            send_frame(8'h77, 1'b1);
            begin
                wait_cycles(138);
                rst_n = 1'b0;
                wait_cycles(1);
                rst_n = 1'b1;
                check("rst_data", data, 8'h00);
                check("rst_valid", valid, 1'b0);
                check("rst_frame_err", frame_err, 1'b0);
                check("rst_overrun", overrun, 1'b0);
            end
        join
        ready = 1'b1;
        wait_cycles(40);
        check("rst_no_valid", rxq.size(), 0);
        check("rst_frame_err_at_most_one", (fe_cnt - fe0) <= 1, 1'b1);
        rxq.delete();
        send_frame(8'h99, 1'b1);
        wait_cycles(20);
        expq.push_back(8'h99);
        check_queue("rst_queue");

        // Random bytes with random idle gaps, consumer always ready
        ov0 = ov_cnt; fe0 = fe_cnt;
        for (int n = 0; n < 10; n++) begin
            rb = 8'($urandom);
            expq.push_back(rb);
            gap = $urandom_range(0, 20);
            for (int g = 0; g < gap; g++) wait_cycles(1);
            send_frame(rb, 1'b1);
        end
        wait_cycles(40);
        check_queue("rand_queue");
        check("rand_no_overrun", ov_cnt - ov0, 0);
        check("rand_no_frame_err", fe_cnt - fe0, 0);
        check("never_both_pulses", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
